// File: rtl/ext_pkg.sv
// Shared constants and types for the immediate-extension arbiter.
package ext_pkg;

  localparam int unsigned DEF_IN_W  = 16;
  localparam int unsigned DEF_OUT_W = 32;

  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/imm_extender.sv
// Combinational immediate extender: zero, sign or upper-load placement.
module imm_extender
  import ext_pkg::*;
#(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned OUT_W = DEF_OUT_W
) (
  input  logic [IN_W-1:0]  In,
  input  logic [1:0]       Mode,
  output logic [OUT_W-1:0] Out
);

  // Mode 11 falls into the default arm and is treated as sign extension.
  always_comb begin
    Out = OUT_W'(In);
    case (Mode)
      EXT_ZERO:  Out = OUT_W'(In);
      EXT_UPPER: Out = OUT_W'(In) << IN_W;
      default:   Out = OUT_W'($signed(In));
    endcase
  end

endmodule

// File: rtl/imm_extend_arbiter.sv
// Round-robin arbiter sharing one immediate extender between decode (A) and
// branch/AGU (B), with a single registered result slot and valid/ready output.
module imm_extend_arbiter
  import ext_pkg::*;
#(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned OUT_W = DEF_OUT_W
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             ReqA,
  input  logic [IN_W-1:0]  ImmA,
  input  logic [1:0]       ModeA,
  output logic             GntA,
  input  logic             ReqB,
  input  logic [IN_W-1:0]  ImmB,
  input  logic [1:0]       ModeB,
  output logic             GntB,
  output logic             OutValid,
  output logic [OUT_W-1:0] OutData,
  output logic             OutSrc,
  input  logic             OutReady
);

  slot_state_t      state;
  slot_state_t      state_nxt;
  logic             last;
  logic             accept;
  logic             grant;
  logic [IN_W-1:0]  sel_imm;
  logic [1:0]       sel_mode;
  logic [OUT_W-1:0] ext_out;

  assign OutValid = (state == S_FULL);
  assign accept   = (state == S_EMPTY) || OutReady;
  assign grant    = GntA || GntB;

  // Grant: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    GntA = 1'b0;
    GntB = 1'b0;
    if (!Rst && accept) begin
      if (ReqA && ReqB) begin
        GntA = (last == SRC_B);
        GntB = (last == SRC_A);
      end else begin
        GntA = ReqA;
        GntB = ReqB;
      end
    end
  end

  assign sel_imm  = GntB ? ImmB  : ImmA;
  assign sel_mode = GntB ? ModeB : ModeA;

  imm_extender #(
    .IN_W (IN_W),
    .OUT_W(OUT_W)
  ) u_ext (
    .In  (sel_imm),
    .Mode(sel_mode),
    .Out (ext_out)
  );

  always_ff @(posedge Clk) begin
    if (Rst) state <= S_EMPTY;
    else     state <= state_nxt;
  end

  // A grant refills the slot even while it drains, so there is no bubble.
  always_comb begin
    state_nxt = state;
    if (grant)                          state_nxt = S_FULL;
    else if (state == S_FULL && OutReady) state_nxt = S_EMPTY;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      OutData <= '0;
      OutSrc  <= SRC_A;
      last    <= SRC_B;
    end else if (grant) begin
      OutData <= ext_out;
      OutSrc  <= GntB ? SRC_B : SRC_A;
      last    <= GntB ? SRC_B : SRC_A;
    end
  end

endmodule

// File: tb/tb_imm_extend_arbiter.sv
// Randomized self-checking bench for imm_extend_arbiter against a behavioural model.
module tb_imm_extend_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, req_b, out_ready;
  logic [15:0] imm_a, imm_b;
  logic [1:0]  mode_a, mode_b;
  logic        gnt_a, gnt_b, out_valid, out_src;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;

  // Model state: contents of the result slot and who was served last.
  logic        m_valid = 1'b0;
  logic [31:0] m_data  = 32'h0;
  logic        m_src   = 1'b0;
  logic        m_last  = 1'b1;
  logic        mg_a = 1'b0, mg_b = 1'b0;

  imm_extend_arbiter #(.IN_W(16), .OUT_W(32)) dut (
    .Clk(clk), .Rst(rst),
    .ReqA(req_a), .ImmA(imm_a), .ModeA(mode_a), .GntA(gnt_a),
    .ReqB(req_b), .ImmB(imm_b), .ModeB(mode_b), .GntB(gnt_b),
    .OutValid(out_valid), .OutData(out_data), .OutSrc(out_src),
    .OutReady(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_ext(input logic [15:0] i, input logic [1:0] m);
    int unsigned v;
    v = 32'(i);
    case (m)
      2'b00:   return v;
      2'b10:   return v * 65536;
      default: return (v >= 32768) ? v + 32'hFFFF0000 : v;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare DUT with model at the negedge, advance the model, step past posedge.
  task automatic cycle();
    logic ga, gb, acc;
    @(negedge clk);
    ga = 1'b0;
    gb = 1'b0;
    acc = !m_valid || out_ready;
    if (!rst && acc) begin
      if (req_a && req_b) begin
        ga = (m_last == 1'b1);
        gb = !ga;
      end else begin
        ga = req_a;
        gb = req_b;
      end
    end
    chk("gnt_a", 32'(gnt_a), 32'(ga));
    chk("gnt_b", 32'(gnt_b), 32'(gb));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid || rst) begin
      chk("out_data", out_data, m_data);
      chk("out_src", 32'(out_src), 32'(m_src));
    end
    if (rst) begin
      m_valid = 1'b0; m_data = 32'h0; m_src = 1'b0; m_last = 1'b1;
    end else if (ga || gb) begin
      m_data  = gb ? ref_ext(imm_b, mode_b) : ref_ext(imm_a, mode_a);
      m_src   = gb;
      m_last  = gb;
      m_valid = 1'b1;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    mg_a = ga;
    mg_b = gb;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] held;

  initial begin
    rst = 1'b1; req_a = 0; req_b = 0; out_ready = 1;
    imm_a = 0; imm_b = 0; mode_a = 0; mode_b = 0;
    @(posedge clk); #1;
    cycle();
    rst = 1'b0;
    #1;
    chk("reset_valid", 32'(out_valid), 32'h0);
    chk("reset_data", out_data, 32'h0);
    chk("reset_src", 32'(out_src), 32'h0);

    // Sign-extend a negative immediate from A.
    req_a = 1; imm_a = 16'h8001; mode_a = 2'b01;
    #1 chk("first_gnt_a", 32'(gnt_a), 32'h1);
    cycle();
    chk("sign_data", out_data, 32'hFFFF8001);
    chk("sign_src", 32'(out_src), 32'h0);
    chk("sign_valid", 32'(out_valid), 32'h1);

    req_a = 0; req_b = 1; imm_b = 16'hFFFF; mode_b = 2'b00;
    cycle();
    chk("zero_data", out_data, 32'h0000FFFF);
    chk("zero_src", 32'(out_src), 32'h1);
    imm_b = 16'h1234; mode_b = 2'b10;
    cycle();
    chk("upper_data", out_data, 32'h12340000);
    req_b = 0;

    // Both requesting after reset: strict alternation starting with A.
    rst = 1; cycle(); rst = 0;
    req_a = 1; req_b = 1;
    for (int k = 0; k < 4; k++) begin
      imm_a = 16'(k); imm_b = 16'(k + 16);
      cycle();
      chk("alt_valid", 32'(out_valid), 32'h1);
      chk("alt_src", 32'(out_src), 32'(k % 2));
    end

    // Back-pressure holds the slot and blocks grants.
    req_b = 0; out_ready = 0; imm_a = 16'h0042; mode_a = 2'b00;
    held = out_data;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_gnt_a", 32'(gnt_a), 32'h0);
      cycle();
      chk("bp_data", out_data, held);
    end
    out_ready = 1;
    #1 chk("bp_release_gnt", 32'(gnt_a), 32'h1);
    cycle();
    chk("bp_new_valid", 32'(out_valid), 32'h1);
    chk("bp_new_data", out_data, 32'h00000042);

    // Reset while full with B waiting.
    req_a = 0; req_b = 1; imm_b = 16'h8000; mode_b = 2'b01; rst = 1;
    #1 chk("rst_gnt_b", 32'(gnt_b), 32'h0);
    cycle();
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", out_data, 32'h0);
    rst = 0;
    #1 chk("post_rst_gnt_b", 32'(gnt_b), 32'h1);
    cycle();
    chk("post_rst_src", 32'(out_src), 32'h1);
    chk("post_rst_data", out_data, 32'hFFFF8000);
    req_b = 0;

    // Mode 11 behaves as sign extension.
    req_a = 1; imm_a = 16'h7FFF; mode_a = 2'b11;
    cycle();
    chk("mode11_data", out_data, 32'h00007FFF);
    req_a = 0;
    cycle();

    // Random traffic: requesters hold until granted, random back-pressure and resets.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(99) == 0);
      out_ready = ($urandom_range(3) != 0);
      if (!req_a || mg_a) begin
        req_a = ($urandom_range(2) != 0);
        imm_a = 16'($urandom);
        mode_a = 2'($urandom);
      end
      if (!req_b || mg_b) begin
        req_b = ($urandom_range(2) != 0);
        imm_b = 16'($urandom);
        mode_b = 2'($urandom);
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
